// File: rtl/proc6_pkg.sv
// proc6_pkg: shared types and constants for the six-instruction processor.
//   opcode_t  - instruction opcodes (IR[15:12]); values 6..15 are illegal.
//   state_t   - control-unit FSM states.
//   RF_S_*    - register-file W-data mux selects (shared with the datapath mux).
//   ALU_S_*   - ALU operation selects (shared with the datapath ALU).
package proc6_pkg;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_ADD   = 4'd2,
    OP_LOADC = 4'd3,
    OP_SUB   = 4'd4,
    OP_JMPZ  = 4'd5
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_LOAD     = 4'd3,
    S_STORE    = 4'd4,
    S_ADD      = 4'd5,
    S_LOADC    = 4'd6,
    S_SUB      = 4'd7,
    S_JMPZ     = 4'd8,
    S_JMPZ_JMP = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  localparam logic [1:0] RF_S_ALU   = 2'b00;
  localparam logic [1:0] RF_S_DREG  = 2'b01;
  localparam logic [1:0] RF_S_WDATA = 2'b10;

  localparam logic [1:0] ALU_S_BYPASS = 2'b00;
  localparam logic [1:0] ALU_S_ADD    = 2'b01;
  localparam logic [1:0] ALU_S_SUB    = 2'b10;

endpackage

// File: rtl/proc6_pc.sv
// proc6_pc: program counter register.
//   clk, rst_n  - clock, synchronous active-low reset (PC -> 0)
//   clr         - PC <- 0
//   inc         - PC <- PC + 1
//   load_off    - PC <- PC + sext(off) - 1 (PC already points past the jump)
//   off         - 8-bit two's-complement jump offset
//   pc          - current PC
// All arithmetic wraps modulo 2^W.
module proc6_pc #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         load_off,
  input  logic [7:0]   off,
  output logic [W-1:0] pc
);

  logic [W-1:0] off_ext;
  assign off_ext = {{(W-8){off[7]}}, off};

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + W'(1);
    end else if (load_off) begin
      pc <= pc + off_ext - W'(1);
    end
  end

endmodule

// File: rtl/proc6_ctrl.sv
// proc6_ctrl: control unit of the six-instruction processor.
// Holds PC and IR, fetches from instruction memory, decodes, and drives
// the register file, W-data mux, ALU and data-memory strobes (Moore outputs).
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   i_addr, i_rd, i_data - instruction memory (combinational read)
//   d_addr, d_rd, d_wr   - data memory
//   rf_*                 - register-file addresses, strobes, constant, mux select
//   alu_s                - ALU operation
//   rf_rp_zero           - Rp read port is zero (resolves JMPZ)
//   halted               - controller stopped on an illegal opcode
//   state_dbg            - current FSM state, for observation
// Build option: PROC6_ILLEGAL_HALT_EN makes an illegal opcode enter HALT;
// without it an illegal opcode is a NOP and halted is always 0.
// Handshake: none; every instruction runs FETCH/DECODE/EXEC unconditionally.
module proc6_ctrl
  import proc6_pkg::*;
#(
  parameter int PC_WIDTH    = 16,
  parameter int REGBITS     = 4,
  parameter int DADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [PC_WIDTH-1:0]    i_addr,
  output logic                   i_rd,
  input  logic [15:0]            i_data,
  output logic [DADDR_WIDTH-1:0] d_addr,
  output logic                   d_rd,
  output logic                   d_wr,
  output logic [7:0]             rf_w_data,
  output logic [REGBITS-1:0]     rf_w_addr,
  output logic [REGBITS-1:0]     rf_rp_addr,
  output logic [REGBITS-1:0]     rf_rq_addr,
  output logic                   rf_w_wr,
  output logic                   rf_rp_rd,
  output logic                   rf_rq_rd,
  output logic [1:0]             rf_s,
  output logic [1:0]             alu_s,
  input  logic                   rf_rp_zero,
  output logic                   halted,
  output logic [3:0]             state_dbg
);

  state_t              state, next;
  logic [15:0]         ir;
  logic [PC_WIDTH-1:0] pc;

  logic [3:0]         op;
  logic [REGBITS-1:0] ra, rb, rc;
  logic [7:0]         imm;
  assign op  = ir[15:12];
  assign ra  = ir[11:8];
  assign rb  = ir[7:4];
  assign rc  = ir[3:0];
  assign imm = ir[7:0];

  proc6_pc #(.W(PC_WIDTH)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == S_INIT),
    .inc      (state == S_FETCH),
    .load_off (state == S_JMPZ_JMP),
    .off      (imm),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_INIT;
      ir    <= '0;
    end else begin
      state <= next;
      if (state == S_FETCH) ir <= i_data;
    end
  end

  assign state_dbg = state;
  // Outputs are forced low while reset is asserted so that an interrupted
  // STORE or register write never reaches memory or the register file.
  assign i_addr = rst_n ? pc : '0;

  always_comb begin
    next       = state;
    i_rd       = 1'b0;
    d_addr     = '0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    rf_w_data  = '0;
    rf_w_addr  = '0;
    rf_rp_addr = '0;
    rf_rq_addr = '0;
    rf_w_wr    = 1'b0;
    rf_rp_rd   = 1'b0;
    rf_rq_rd   = 1'b0;
    rf_s       = RF_S_ALU;
    alu_s      = ALU_S_BYPASS;
    halted     = 1'b0;
    if (rst_n) begin
      case (state)
        S_INIT:  next = S_FETCH;
        S_FETCH: begin
          i_rd = 1'b1;
          next = S_DECODE;
        end
        S_DECODE: begin
          case (op)
            OP_LOAD:  next = S_LOAD;
            OP_STORE: next = S_STORE;
            OP_ADD:   next = S_ADD;
            OP_LOADC: next = S_LOADC;
            OP_SUB:   next = S_SUB;
            OP_JMPZ:  next = S_JMPZ;
`ifdef PROC6_ILLEGAL_HALT_EN
            default:  next = S_HALT;
`else
            default:  next = S_FETCH;
`endif
          endcase
        end
        S_LOAD: begin
          d_addr    = imm[DADDR_WIDTH-1:0];
          d_rd      = 1'b1;
          rf_s      = RF_S_DREG;
          rf_w_addr = ra;
          rf_w_wr   = 1'b1;
          next      = S_FETCH;
        end
        S_STORE: begin
          d_addr     = imm[DADDR_WIDTH-1:0];
          d_wr       = 1'b1;
          rf_rp_addr = ra;
          rf_rp_rd   = 1'b1;
          next       = S_FETCH;
        end
        S_ADD, S_SUB: begin
          rf_rp_addr = rb;
          rf_rq_addr = rc;
          rf_rp_rd   = 1'b1;
          rf_rq_rd   = 1'b1;
          alu_s      = (state == S_ADD) ? ALU_S_ADD : ALU_S_SUB;
          rf_s       = RF_S_ALU;
          rf_w_addr  = ra;
          rf_w_wr    = 1'b1;
          next       = S_FETCH;
        end
        S_LOADC: begin
          rf_w_data = imm;
          rf_s      = RF_S_WDATA;
          rf_w_addr = ra;
          rf_w_wr   = 1'b1;
          next      = S_FETCH;
        end
        S_JMPZ: begin
          rf_rp_addr = ra;
          rf_rp_rd   = 1'b1;
          next       = rf_rp_zero ? S_JMPZ_JMP : S_FETCH;
        end
        S_JMPZ_JMP: next = S_FETCH;
        S_HALT: begin
          // Only reachable with the illegal-halt option; sticks until reset.
`ifdef PROC6_ILLEGAL_HALT_EN
          halted = 1'b1;
`endif
          next = S_HALT;
        end
        default: next = S_INIT;
      endcase
    end
  end

endmodule
